// File: rtl/bpred_pkg.sv
// Shared constants for the branch-predictor front end.
//   GHR_SIZE / HOB / LOB : global-history geometry
//   *_AW                 : address widths of the three storage instances
//   *_W                  : word widths of the three storage instances
package bpred_pkg;

    localparam int unsigned GHR_SIZE      = 8;
    localparam int unsigned HOB           = 3;
    localparam int unsigned LOB           = 5;

    localparam int unsigned WEIGHT_TBL_AW = 6;
    localparam int unsigned IMEM_AW       = 8;
    localparam int unsigned RAS_AW        = 4;

    localparam int unsigned WEIGHT_W      = 24;
    localparam int unsigned IMEM_W        = 32;
    localparam int unsigned RAS_W         = 32;

    // Instruction-store index for a byte PC (word-aligned, IMEM_AW bits above bit 1).
    function automatic logic [IMEM_AW-1:0] pc_to_imem_addr(input logic [31:0] pc);
        return pc[IMEM_AW+1:2];
    endfunction

endpackage

// File: rtl/MLAB_32_4.sv
// Return-address stack: 16 x 32, single-port; rdaddress is the RAS index.
// Ports: clock, reset, data, rdaddress, wraddress (ignored), wren, q (see hob_ram).
module MLAB_32_4
    import bpred_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic [RAS_W-1:0]  data,
    input  logic [RAS_AW-1:0] rdaddress,
    input  logic [RAS_AW-1:0] wraddress,
    input  logic              wren,
    output logic [RAS_W-1:0]  q
);

    hob_ram #(
        .DATA_W      (RAS_W),
        .ADDR_W      (RAS_AW),
        .SINGLE_PORT (1),
        .RDW_NEW     (0),
        .INIT_ZERO   (1)
    ) u_ram (
        .clock     (clock),
        .reset     (reset),
        .data      (data),
        .rdaddress (rdaddress),
        .wraddress (wraddress),
        .wren      (wren),
        .q         (q)
    );

endmodule

// File: rtl/hobRam.sv
// Perceptron weight table: 64 x 24, simple dual-port, old-data on read-during-write.
// Ports: clock, reset, data, rdaddress, wraddress, wren, q (see hob_ram).
module hobRam
    import bpred_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WEIGHT_W-1:0]      data,
    input  logic [WEIGHT_TBL_AW-1:0] rdaddress,
    input  logic [WEIGHT_TBL_AW-1:0] wraddress,
    input  logic                     wren,
    output logic [WEIGHT_W-1:0]      q
);

    hob_ram #(
        .DATA_W      (WEIGHT_W),
        .ADDR_W      (WEIGHT_TBL_AW),
        .SINGLE_PORT (0),
        .RDW_NEW     (0),
        .INIT_ZERO   (1)
    ) u_ram (
        .clock     (clock),
        .reset     (reset),
        .data      (data),
        .rdaddress (rdaddress),
        .wraddress (wraddress),
        .wren      (wren),
        .q         (q)
    );

endmodule

// File: rtl/insnMem.sv
// Instruction store: 256 x 32, simple dual-port. Read address is PC[9:2] from the caller.
// Ports: clock, reset, data, rdaddress, wraddress, wren, q (see hob_ram).
module insnMem
    import bpred_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic [IMEM_W-1:0]  data,
    input  logic [IMEM_AW-1:0] rdaddress,
    input  logic [IMEM_AW-1:0] wraddress,
    input  logic               wren,
    output logic [IMEM_W-1:0]  q
);

    hob_ram #(
        .DATA_W      (IMEM_W),
        .ADDR_W      (IMEM_AW),
        .SINGLE_PORT (0),
        .RDW_NEW     (0),
        .INIT_ZERO   (1)
    ) u_ram (
        .clock     (clock),
        .reset     (reset),
        .data      (data),
        .rdaddress (rdaddress),
        .wraddress (wraddress),
        .wren      (wren),
        .q         (q)
    );

endmodule

// File: rtl/hob_ram.sv
// Parameterised synchronous RAM with a registered read port.
// Ports:
//   clock      - single clock, all ports sampled on its rising edge
//   reset      - synchronous active-high, clears only the read register
//   data       - write data
//   rdaddress  - read address (also write address when SINGLE_PORT=1)
//   wraddress  - write address (ignored when SINGLE_PORT=1)
//   wren       - write enable
//   q          - registered read data, 1-cycle latency
module hob_ram
    import bpred_pkg::*;
#(
    parameter int unsigned DATA_W      = WEIGHT_W,
    parameter int unsigned ADDR_W      = WEIGHT_TBL_AW,
    parameter int unsigned SINGLE_PORT = 0,
    parameter int unsigned RDW_NEW     = 0,
    parameter int unsigned INIT_ZERO   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data,
    input  logic [ADDR_W-1:0] rdaddress,
    input  logic [ADDR_W-1:0] wraddress,
    input  logic              wren,
    output logic [DATA_W-1:0] q
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    // 'x lets the tools treat power-up contents as don't-care.
    localparam logic [DATA_W-1:0] INIT_WORD = (INIT_ZERO != 0) ? '0 : 'x;

    // No reset on the array so it maps onto block RAM / MLAB.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT_WORD};

    logic [DATA_W-1:0] rd_q;
    logic [ADDR_W-1:0] waddr;
    logic              bypass;
    logic              unused_wraddress;

    assign waddr            = (SINGLE_PORT != 0) ? rdaddress : wraddress;
    assign unused_wraddress = ^wraddress;

    // New-data read-during-write: forward the write data around the array.
    assign bypass = (RDW_NEW != 0) && wren && (waddr == rdaddress);

    // Writes proceed regardless of reset; the predictor initialises its table that way.
    always_ff @(posedge clock) begin
        if (wren) begin
            mem[waddr] <= data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_q <= '0;
        end else if (bypass) begin
            rd_q <= data;
        end else begin
            rd_q <= mem[rdaddress];
        end
    end

    assign q = rd_q;

endmodule

// File: tb/tb_hob_ram.sv
// Bench for hob_ram: four instances (weight table, new-data variant, RAS, instruction
// store) driven from directed and random stimulus and compared each cycle to array models.
module tb_hob_ram;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    // Weight table, 64x24, old data on RDW
    logic [23:0] wt_d, wt_q;
    logic [5:0]  wt_ra, wt_wa;
    logic        wt_we;
    // Same geometry, new data on RDW
    logic [23:0] nw_d, nw_q;
    logic [5:0]  nw_ra, nw_wa;
    logic        nw_we;
    // RAS, 16x32 single-port
    logic [31:0] ras_d, ras_q;
    logic [3:0]  ras_a, ras_wa;
    logic        ras_we;
    // Instruction store, 256x32
    logic [31:0] im_d, im_q;
    logic [7:0]  im_ra, im_wa;
    logic        im_we;

    hobRam u_wt (
        .clock(clock), .reset(reset), .data(wt_d), .rdaddress(wt_ra),
        .wraddress(wt_wa), .wren(wt_we), .q(wt_q)
    );

    hob_ram #(
        .DATA_W(24), .ADDR_W(6), .SINGLE_PORT(0), .RDW_NEW(1), .INIT_ZERO(1)
    ) u_nw (
        .clock(clock), .reset(reset), .data(nw_d), .rdaddress(nw_ra),
        .wraddress(nw_wa), .wren(nw_we), .q(nw_q)
    );

    MLAB_32_4 u_ras (
        .clock(clock), .reset(reset), .data(ras_d), .rdaddress(ras_a),
        .wraddress(ras_wa), .wren(ras_we), .q(ras_q)
    );

    insnMem u_im (
        .clock(clock), .reset(reset), .data(im_d), .rdaddress(im_ra),
        .wraddress(im_wa), .wren(im_we), .q(im_q)
    );

    // Reference contents
    logic [23:0] m_wt [64];
    logic [23:0] m_nw [64];
    logic [31:0] m_ras [16];
    logic [31:0] m_im [256];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // One clock edge: predict q of every instance, update the models, then compare.
    task automatic cycle(input string tag);
        logic [31:0] e_wt, e_nw, e_ras, e_im;
        e_wt  = reset ? 32'd0 : 32'(m_wt[wt_ra]);
        e_nw  = reset ? 32'd0 : (nw_we && nw_wa == nw_ra) ? 32'(nw_d) : 32'(m_nw[nw_ra]);
        e_ras = reset ? 32'd0 : m_ras[ras_a];
        e_im  = reset ? 32'd0 : m_im[im_ra];
        if (wt_we)  m_wt[wt_wa]  = wt_d;
        if (nw_we)  m_nw[nw_wa]  = nw_d;
        if (ras_we) m_ras[ras_a] = ras_d;
        if (im_we)  m_im[im_wa]  = im_d;
        @(posedge clock);
        #1;
        check_eq({tag, ".wt"}, 32'(wt_q), e_wt);
        check_eq({tag, ".nw"}, 32'(nw_q), e_nw);
        check_eq({tag, ".ras"}, ras_q, e_ras);
        check_eq({tag, ".im"}, im_q, e_im);
    endtask

    task automatic idle_writes();
        wt_we = 1'b0; nw_we = 1'b0; ras_we = 1'b0; im_we = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin m_wt[i] = '0; m_nw[i] = '0; end
        for (int i = 0; i < 16; i++) m_ras[i] = '0;
        for (int i = 0; i < 256; i++) m_im[i] = '0;
        reset = 1'b1;
        idle_writes();
        wt_d = '0; wt_ra = '0; wt_wa = '0;
        nw_d = '0; nw_ra = '0; nw_wa = '0;
        ras_d = '0; ras_a = '0; ras_wa = '0;
        im_d = '0; im_ra = '0; im_wa = '0;
        cycle("reset");
        cycle("reset2");

        // Power-up zero, then write and read back
        reset = 1'b0;
        wt_ra = 6'd5;
        cycle("init_read5");
        check_eq("init_read5_const", 32'(wt_q), 32'h0);
        wt_we = 1'b1; wt_wa = 6'd5; wt_d = 24'hABCDEF;
        cycle("write5");
        wt_we = 1'b0;
        cycle("read5");
        check_eq("read5_const", 32'(wt_q), 32'h00ABCDEF);

        // Read-during-write at address 9
        wt_we = 1'b1; wt_wa = 6'd9; wt_d = 24'h000111;
        nw_we = 1'b1; nw_wa = 6'd9; nw_d = 24'h000111;
        cycle("rdw_pre");
        wt_ra = 6'd9; wt_d = 24'h123456;
        nw_ra = 6'd9; nw_d = 24'h123456;
        cycle("rdw");
        check_eq("rdw_old_const", 32'(wt_q), 32'h00000111);
        check_eq("rdw_new_const", 32'(nw_q), 32'h00123456);
        idle_writes();
        cycle("rdw_after");
        check_eq("rdw_after_const", 32'(wt_q), 32'h00123456);

        // Single-port RAS; wraddress wiggles and must be ignored
        ras_we = 1'b1; ras_a = 4'd3; ras_d = 32'h00000040; ras_wa = 4'd4;
        cycle("ras_w3");
        ras_a = 4'd4; ras_d = 32'h00000080; ras_wa = 4'd3;
        cycle("ras_w4");
        ras_we = 1'b0; ras_a = 4'd3; ras_wa = 4'd15;
        cycle("ras_r3");
        check_eq("ras_r3_const", ras_q, 32'h00000040);

        // Reset keeps contents
        im_we = 1'b1; im_wa = 8'd255; im_d = 32'hDEADBEEF;
        cycle("im_w255");
        im_we = 1'b0; im_ra = 8'd255; reset = 1'b1;
        cycle("im_rst_read");
        check_eq("im_rst_const", im_q, 32'h0);
        reset = 1'b0;
        cycle("im_read255");
        check_eq("im_read255_const", im_q, 32'hDEADBEEF);

        // Write during reset takes effect
        reset = 1'b1; wt_we = 1'b1; wt_wa = 6'd7; wt_d = 24'h00000A; wt_ra = 6'd7;
        cycle("wr_in_rst");
        reset = 1'b0; wt_we = 1'b0;
        cycle("wr_in_rst_read");
        check_eq("wr_in_rst_const", 32'(wt_q), 32'h0000000A);

        // Sweep write addr->addr, then back-to-back reads
        im_we = 1'b1;
        for (int i = 0; i < 256; i++) begin
            im_wa = 8'(i); im_d = 32'(i);
            cycle("sweep_w");
        end
        im_we = 1'b0;
        for (int i = 0; i < 256; i++) begin
            im_ra = 8'(i);
            cycle("sweep_r");
            check_eq("sweep_prev_addr", im_q, 32'(i));
        end

        // Random traffic on all instances, with occasional reset
        for (int n = 0; n < 400; n++) begin
            reset  = ($urandom_range(0, 31) == 0);
            wt_we  = $urandom_range(0, 1) == 1;  wt_d = 24'($urandom());
            wt_ra  = 6'($urandom());             wt_wa = 6'($urandom_range(0, 3) == 0 ? wt_ra : 6'($urandom()));
            nw_we  = $urandom_range(0, 1) == 1;  nw_d = 24'($urandom());
            nw_ra  = 6'($urandom_range(0, 7));   nw_wa = 6'($urandom_range(0, 7));
            ras_we = $urandom_range(0, 1) == 1;  ras_d = $urandom();
            ras_a  = 4'($urandom());             ras_wa = 4'($urandom());
            im_we  = $urandom_range(0, 1) == 1;  im_d = $urandom();
            im_ra  = 8'($urandom_range(0, 15));  im_wa = 8'($urandom_range(0, 15));
            cycle("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
